// File: rtl/cdc_handshake_tx_if.sv
// Signal bundle between a word producer / destination domain and the
// source-side half of the four-phase req/ack crossing.
interface cdc_handshake_tx_if #(
  parameter int BW = 32
) ();
  logic          in_valid;
  logic [BW-1:0] in_data;
  logic          in_ready;
  logic          xfer_req;
  logic [BW-1:0] xfer_data;
  logic          xfer_ack;
  logic          done;
  logic [15:0]   xfer_cnt;
  logic          timeout_err;

  modport master (
    output in_valid, in_data, xfer_ack,
    input  in_ready, xfer_req, xfer_data, done, xfer_cnt, timeout_err
  );

  modport slave (
    input  in_valid, in_data, xfer_ack,
    output in_ready, xfer_req, xfer_data, done, xfer_cnt, timeout_err
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source-domain half of a four-phase req/ack crossing: accepts a word,
// holds it on xfer_data, and walks req up/down against a synchronized ack.
module cdc_handshake_tx #(
  parameter int BW     = 32,
  parameter int TO_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  cdc_handshake_tx_if.slave  bus
);

  localparam int CW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TO_CYC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            ack_meta_r;
  logic            ack_sync_r;
  logic            in_ready_s;
  logic            accept_s;
  logic            ack_seen_s;
  logic            release_s;
  logic            phase_active_s;
  logic            to_hit_s;
  logic [CW-1:0]   phase_cnt_r;
  logic [CW-1:0]   phase_nxt_s;
  logic            xfer_req_r;
  logic [BW-1:0]   xfer_data_r;
  logic            done_r;
  logic [15:0]     xfer_cnt_r;
  logic            timeout_err_r;

  // Two-flop synchronizer for the asynchronous acknowledge level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_r <= 1'b0;
      ack_sync_r <= 1'b0;
    end else begin
      ack_meta_r <= bus.xfer_ack;
      ack_sync_r <= ack_meta_r;
    end
  end

  // A stale high ack must clear before a new word may start.
  assign in_ready_s = (state_r == ST_IDLE) && !ack_sync_r;

  // Next-state and phase-counter decode.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    ack_seen_s  = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_s) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack_sync_r) begin
          ack_seen_s  = 1'b1;
          state_nxt_s = ST_REL;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_REL: begin
        if (!ack_sync_r) begin
          release_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    phase_active_s = (state_r == ST_REQ) || (state_r == ST_REL);
    if (state_nxt_s != state_r) begin
      phase_nxt_s = '0;
    end else if (phase_active_s && (TO_CYC != 0) && (phase_cnt_r != TO_MAX)) begin
      phase_nxt_s = phase_cnt_r + CW'(1);
    end else begin
      phase_nxt_s = phase_cnt_r;
    end
    to_hit_s = (TO_CYC != 0) && phase_active_s && (state_nxt_s == state_r)
               && (phase_nxt_s == TO_MAX);
  end

  // FSM state plus the registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      xfer_req_r  <= 1'b0;
      xfer_data_r <= '0;
      done_r      <= 1'b0;
      xfer_cnt_r  <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= release_s;
      if (accept_s) begin
        xfer_req_r  <= 1'b1;
        xfer_data_r <= bus.in_data;
      end else if (ack_seen_s) begin
        xfer_req_r  <= 1'b0;
      end
      if (release_s) begin
        xfer_cnt_r <= xfer_cnt_r + 16'd1;
      end
    end
  end

  // Per-phase watchdog; the error is sticky and the FSM never aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt_r   <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      phase_cnt_r <= phase_nxt_s;
      if (to_hit_s) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.xfer_req    = xfer_req_r;
  assign bus.xfer_data   = xfer_data_r;
  assign bus.done        = done_r;
  assign bus.xfer_cnt    = xfer_cnt_r;
  assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: words pushed to a scoreboard on
// acceptance are compared against xfer_data when xfer_req rises.
module tb_cdc_handshake_tx;

  localparam int BW = 32;
  localparam int TO = 8;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   base     = 0;
  int   acc      = 0;
  logic acc_now;
  logic prev_req = 1'b0;
  logic auto_ack = 1'b0;
  logic [BW-1:0] held = '0;
  logic [BW-1:0] sb_q[$];

  cdc_handshake_tx_if #(.BW(BW)) bus ();

  cdc_handshake_tx #(.BW(BW), .TO_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record acceptance, advance, then monitor at the falling edge.
  task automatic step();
    logic [BW-1:0] e;
    if (bus.in_valid && bus.in_ready && rst_n) sb_q.push_back(bus.in_data);
    @(posedge clk);
    @(negedge clk);
    if (bus.done) done_cnt++;
    if (bus.xfer_req && !prev_req) begin
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e    = sb_q.pop_front();
        held = e;
        chk("sb_data", 64'(bus.xfer_data), 64'(e));
      end
    end else if (bus.xfer_req) begin
      chk("data_hold", 64'(bus.xfer_data), 64'(held));
    end
    prev_req = bus.xfer_req;
    if (auto_ack) bus.xfer_ack = bus.xfer_req;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.xfer_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req",      64'(bus.xfer_req),    64'd0);
    chk("rst_data",     64'(bus.xfer_data),   64'd0);
    chk("rst_done",     64'(bus.done),        64'd0);
    chk("rst_cnt",      64'(bus.xfer_cnt),    64'd0);
    chk("rst_to",       64'(bus.timeout_err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready),    64'd1);
    rst_n = 1'b1;
    step();

    // Single transfer with hand-driven ack.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h12345678;
    chk("t1_req",      64'(bus.xfer_req),  64'd1);
    chk("t1_data",     64'(bus.xfer_data), 64'hDEADBEEF);
    chk("t1_in_ready", 64'(bus.in_ready),  64'd0);
    step();
    step();
    bus.xfer_ack = 1'b1;
    step();
    chk("t2_req_a0", 64'(bus.xfer_req), 64'd1);
    step();
    chk("t2_req_a1", 64'(bus.xfer_req), 64'd1);
    step();
    chk("t2_req_a2", 64'(bus.xfer_req), 64'd0);
    step();
    step();
    bus.xfer_ack = 1'b0;
    base = done_cnt;
    step();
    chk("t2_done_b0", 64'(bus.done), 64'd0);
    step();
    chk("t2_done_b1",  64'(bus.done),     64'd0);
    chk("t2_ready_b1", 64'(bus.in_ready), 64'd0);
    step();
    chk("t2_done_b2",  64'(bus.done),      64'd1);
    chk("t2_cnt",      64'(bus.xfer_cnt),  64'd1);
    chk("t2_ready_b2", 64'(bus.in_ready),  64'd1);
    chk("t2_data",     64'(bus.xfer_data), 64'hDEADBEEF);
    step();
    chk("t2_done_off", 64'(bus.done), 64'd0);
    chk("t2_pulses",   64'(done_cnt - base), 64'd1);

    // Ten back-to-back transfers against an echoing ack.
    auto_ack     = 1'b1;
    bus.in_data  = '0;
    bus.in_valid = 1'b1;
    acc          = 0;
    base         = done_cnt;
    for (int i = 0; i < 300 && (done_cnt - base) < 10; i++) begin
      acc_now = bus.in_valid && bus.in_ready;
      step();
      if (acc_now) begin
        acc++;
        bus.in_data = bus.in_data + 32'd1;
        if (acc == 10) bus.in_valid = 1'b0;
      end
    end
    auto_ack     = 1'b0;
    bus.xfer_ack = 1'b0;
    chk("b2b_pulses",  64'(done_cnt - base),   64'd10);
    chk("b2b_accepts", 64'(acc),               64'd10);
    chk("b2b_cnt",     64'(bus.xfer_cnt),      64'd11);
    chk("b2b_sb",      64'(sb_q.size()),       64'd0);
    chk("b2b_to",      64'(bus.timeout_err),   64'd0);
    step();

    // Phase timeout with a late ack.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hA5A50004;
    step();
    bus.in_valid = 1'b0;
    repeat (7) step();
    chk("to_before", 64'(bus.timeout_err), 64'd0);
    step();
    chk("to_hit",     64'(bus.timeout_err), 64'd1);
    chk("to_req_hit", 64'(bus.xfer_req),    64'd1);
    repeat (3) step();
    chk("to_req_wait", 64'(bus.xfer_req), 64'd1);
    bus.xfer_ack = 1'b1;
    for (int i = 0; i < 10 && bus.xfer_req; i++) step();
    chk("to_req_fall", 64'(bus.xfer_req), 64'd0);
    bus.xfer_ack = 1'b0;
    base = done_cnt;
    for (int i = 0; i < 10 && done_cnt == base; i++) step();
    chk("to_pulses", 64'(done_cnt - base),   64'd1);
    chk("to_cnt",    64'(bus.xfer_cnt),      64'd12);
    chk("to_sticky", 64'(bus.timeout_err),   64'd1);
    chk("to_data",   64'(bus.xfer_data),     64'hA5A50004);

    // Ack held high across reset release.
    rst_n        = 1'b0;
    bus.xfer_ack = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("ah_ready",  64'(bus.in_ready),    64'd0);
    chk("ah_to_clr", 64'(bus.timeout_err), 64'd0);
    chk("ah_cnt",    64'(bus.xfer_cnt),    64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00000BAD;
    repeat (3) step();
    chk("ah_req",    64'(bus.xfer_req), 64'd0);
    chk("ah_ready2", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    bus.xfer_ack = 1'b0;
    step();
    chk("ah_ready_b0", 64'(bus.in_ready), 64'd0);
    step();
    chk("ah_ready_b1", 64'(bus.in_ready), 64'd1);

    // Reset asserted between edges while in REQ.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hCAFE0006;
    step();
    bus.in_valid = 1'b0;
    chk("mr_req_up", 64'(bus.xfer_req), 64'd1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_req_drop", 64'(bus.xfer_req),  64'd0);
    chk("mr_cnt",      64'(bus.xfer_cnt),  64'd0);
    chk("mr_data",     64'(bus.xfer_data), 64'd0);
    chk("mr_ready",    64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    prev_req = bus.xfer_req;
    auto_ack = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00000007;
    step();
    bus.in_valid = 1'b0;
    base = done_cnt;
    for (int i = 0; i < 20 && done_cnt == base; i++) step();
    auto_ack     = 1'b0;
    bus.xfer_ack = 1'b0;
    chk("mr_pulses", 64'(done_cnt - base),  64'd1);
    chk("mr_cnt2",   64'(bus.xfer_cnt),     64'd1);
    chk("mr_data2",  64'(bus.xfer_data),    64'h7);
    chk("mr_to",     64'(bus.timeout_err),  64'd0);
    chk("end_sb",    64'(sb_q.size()),      64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
